// File: rtl/ble_rx_pkg.sv
// Shared types and constants for the BLE receive path.
package ble_rx_pkg;

   typedef enum logic [1:0] {IDLE, SEARCH, LOCKED} state_t;
   typedef enum logic [1:0] {NONE, HOLD, SKIP} corr_t;

   localparam logic [7:0] PREAMBLE_A = 8'h55;
   localparam logic [7:0] PREAMBLE_B = 8'hAA;
   localparam int         SPS_DEF    = 16;

endpackage

// File: rtl/mf_phase_tracker.sv
// Sample-phase counter, mf_update strobe, HOLD/SKIP timing correction and lock-loss counter.
// MF_TIMING_TRACK_EN undefined: counter free-runs, loss stays low.
module mf_phase_tracker
   import ble_rx_pkg::*;
#(
   parameter int SPS       = SPS_DEF,
   parameter int SAMPLE_PT = SPS / 2,
   parameter int LOSS_SYMS = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic active,
   input  logic mf_decision,
   input  logic loss_clr,
   output logic mf_update,
   output logic wrap,
   output logic loss
);
   localparam int PW = $clog2(SPS);
   typedef logic [PW-1:0] phase_t;
   localparam phase_t LAST = phase_t'(SPS - 1);
   localparam phase_t SMP  = phase_t'(SAMPLE_PT);
   localparam phase_t ONE  = phase_t'(1);

   phase_t phase_cnt;
   logic   wrap_q;

   assign mf_update = active && (phase_cnt == SMP);
   assign wrap      = wrap_q;

`ifdef MF_TIMING_TRACK_EN
   localparam int LW = $clog2(LOSS_SYMS + 1);
   typedef logic [LW-1:0] loss_t;
   localparam loss_t  LOSS_MAX = loss_t'(LOSS_SYMS);
   localparam phase_t HALF     = phase_t'(SPS / 2);

   logic  prev_decision, seen, held, trans;
   corr_t pend, corr_now, corr_eff;
   loss_t loss_cnt;

   assign trans = mf_decision != prev_decision;
   assign loss  = loss_cnt == LOSS_MAX;

   // wrap_q marks the first cycle of a symbol, so a transition there is phase 0
   always_comb begin
      corr_now = NONE;
      if (trans && !seen && !wrap_q && (phase_cnt != '0))
         corr_now = (phase_cnt < HALF) ? HOLD : SKIP;
      corr_eff = (pend != NONE) ? pend : corr_now;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase_cnt     <= '0;
         wrap_q        <= 1'b0;
         prev_decision <= 1'b0;
         seen          <= 1'b0;
         held          <= 1'b0;
         pend          <= NONE;
         loss_cnt      <= '0;
      end else if (!active) begin
         phase_cnt     <= '0;
         wrap_q        <= 1'b0;
         prev_decision <= 1'b0;
         seen          <= 1'b0;
         held          <= 1'b0;
         pend          <= NONE;
         loss_cnt      <= '0;
      end else begin
         prev_decision <= mf_decision;
         seen          <= wrap_q ? trans : (seen | trans);
         wrap_q        <= 1'b0;
         if (loss_clr || (wrap_q && seen))
            loss_cnt <= '0;
         else if (wrap_q && !loss)
            loss_cnt <= loss_cnt + loss_t'(1);
         if (phase_cnt == LAST) begin
            pend <= NONE;
            if ((corr_eff == HOLD) && !held) begin
               held <= 1'b1;
            end else begin
               held      <= 1'b0;
               wrap_q    <= 1'b1;
               phase_cnt <= (corr_eff == SKIP) ? ONE : '0;
            end
         end else begin
            pend      <= corr_eff;
            phase_cnt <= phase_cnt + ONE;
         end
      end
   end
`else
   logic unused_inputs;
   assign unused_inputs = mf_decision ^ loss_clr;
   assign loss          = 1'b0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase_cnt <= '0;
         wrap_q    <= 1'b0;
      end else if (!active) begin
         phase_cnt <= '0;
         wrap_q    <= 1'b0;
      end else begin
         phase_cnt <= phase_cnt + ONE;
         wrap_q    <= phase_cnt == LAST;
      end
   end
`endif

endmodule

// File: rtl/mf_symbol_sync.sv
// Symbol-timing controller and bit framer after Matched_Filter: preamble hunt, lock, bit delivery.
// Timing tracking (HOLD/SKIP, lock loss) is built in when MF_TIMING_TRACK_EN is defined.
//
// state  | meaning
// IDLE   | disabled, counters and outputs held at 0
// SEARCH | slicing bits into the shift register, hunting for 0x55 / 0xAA
// LOCKED | delivering framed bits until MAX_BITS or lock loss
module mf_symbol_sync
   import ble_rx_pkg::*;
#(
   parameter int SPS       = SPS_DEF,
   parameter int SAMPLE_PT = SPS / 2,
   parameter int MAX_BITS  = 2120,
   parameter int LOSS_SYMS = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        mf_decision,
   output logic        mf_update,
   output logic        bit_valid,
   output logic        bit_data,
   output logic        preamble_det,
   output logic        locked,
   output logic [11:0] bit_cnt
);
   localparam logic [11:0] MAX_CNT = 12'(MAX_BITS);

   state_t     state;
   logic [7:0] sreg;
   logic [7:0] sreg_next;
   logic       active, match, loss, loss_clr, budget_done, unused_wrap;

   assign active      = en && (state != IDLE);
   assign sreg_next   = {sreg[6:0], mf_decision};
   assign match       = (sreg_next == PREAMBLE_A) || (sreg_next == PREAMBLE_B);
   assign loss_clr    = (state == SEARCH) && mf_update && match;
   assign budget_done = mf_update && ((bit_cnt + 12'd1) == MAX_CNT);

   mf_phase_tracker #(
      .SPS       (SPS),
      .SAMPLE_PT (SAMPLE_PT),
      .LOSS_SYMS (LOSS_SYMS)
   ) u_tracker (
      .clk         (clk),
      .rst         (rst),
      .active      (active),
      .mf_decision (mf_decision),
      .loss_clr    (loss_clr),
      .mf_update   (mf_update),
      .wrap        (unused_wrap),
      .loss        (loss)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         sreg         <= '0;
         bit_valid    <= 1'b0;
         bit_data     <= 1'b0;
         preamble_det <= 1'b0;
         locked       <= 1'b0;
         bit_cnt      <= '0;
      end else if (!en) begin
         state        <= IDLE;
         sreg         <= '0;
         bit_valid    <= 1'b0;
         bit_data     <= 1'b0;
         preamble_det <= 1'b0;
         locked       <= 1'b0;
         bit_cnt      <= '0;
      end else begin
         bit_valid    <= 1'b0;
         preamble_det <= 1'b0;
         case (state)
            IDLE: state <= SEARCH;
            SEARCH: begin
               if (mf_update) begin
                  sreg <= sreg_next;
                  if (match) begin
                     state        <= LOCKED;
                     locked       <= 1'b1;
                     preamble_det <= 1'b1;
                     bit_cnt      <= '0;
                  end
               end
            end
            LOCKED: begin
               if (mf_update) begin
                  sreg      <= sreg_next;
                  bit_valid <= 1'b1;
                  bit_data  <= mf_decision;
                  bit_cnt   <= bit_cnt + 12'd1;
               end
               if (budget_done || loss) begin
                  state  <= SEARCH;
                  locked <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mf_symbol_sync.sv
// Directed bench for mf_symbol_sync (MAX_BITS = 20): symbol table for the ideal stream plus timing/loss/enable sequences.
module tb_mf_symbol_sync;

   logic        clk = 1'b0;
   logic        rst, en, mf_decision;
   logic        mf_update, bit_valid, bit_data, preamble_det, locked;
   logic [11:0] bit_cnt;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   always #5 clk = ~clk;

   mf_symbol_sync #(.MAX_BITS(20)) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .mf_decision  (mf_decision),
      .mf_update    (mf_update),
      .bit_valid    (bit_valid),
      .bit_data     (bit_data),
      .preamble_det (preamble_det),
      .locked       (locked),
      .bit_cnt      (bit_cnt)
   );

   typedef struct {
      int d;
      int bv;
      int bd;
      int pd;
      int lk;
      int cnt;
   } vec_t;

   // per symbol k: driven level, then outputs expected at phase 9 (one cycle after the slice)
   vec_t tbl [30] = '{
      '{0,0,0,0,0,0}, '{1,0,0,0,0,0}, '{0,0,0,0,0,0}, '{1,0,0,0,0,0}, '{0,0,0,0,0,0},
      '{1,0,0,0,0,0}, '{0,0,0,0,0,0}, '{1,0,0,1,1,0}, '{0,1,0,0,1,1}, '{1,1,1,0,1,2},
      '{0,1,0,0,1,3}, '{1,1,1,0,1,4}, '{0,1,0,0,1,5}, '{1,1,1,0,1,6}, '{0,1,0,0,1,7},
      '{1,1,1,0,1,8}, '{0,1,0,0,1,9}, '{1,1,1,0,1,10},'{0,1,0,0,1,11},'{1,1,1,0,1,12},
      '{0,1,0,0,1,13},'{1,1,1,0,1,14},'{0,1,0,0,1,15},'{1,1,1,0,1,16},'{0,1,0,0,1,17},
      '{1,1,1,0,1,18},'{0,1,0,0,1,19},'{1,1,1,0,0,20},'{0,0,1,1,1,0}, '{1,1,1,0,1,1}
   };

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step(input logic d);
      @(posedge clk);
      #1;
      mf_decision = d;
      cyc++;
   endtask

   // leaves en high in an IDLE cycle; the next step() is cycle 0 of SEARCH (phase 0)
   task automatic restart();
      en          = 1'b0;
      mf_decision = 1'b0;
      repeat (3) step(1'b0);
      en  = 1'b1;
      cyc = -1;
   endtask

   task automatic phase_run(input string name, input int off,
                            input int e0, input int e1, input int e2, input int e3, input int e4);
      int t [6];
      int np;
      np = 0;
      for (int i = 0; i < 6; i++) t[i] = 0;
      restart();
      for (int n = 0; n < 130; n++) begin
         step((n >= off) && ((((n - off) / 16) % 2) == 0));
         if (mf_update && (np < 6)) begin
            t[np] = cyc;
            np++;
         end
      end
      check({name, "_pulses"}, np, 6);
      check({name, "_first"}, t[0], 8);
      check({name, "_iv0"}, t[1] - t[0], e0);
      check({name, "_iv1"}, t[2] - t[1], e1);
      check({name, "_iv2"}, t[3] - t[2], e2);
      check({name, "_iv3"}, t[4] - t[3], e3);
      check({name, "_iv4"}, t[5] - t[4], e4);
   endtask

   initial begin
      int hits;
      int k;
      rst = 1'b0; en = 1'b0; mf_decision = 1'b0;

      // reset and IDLE
      repeat (3) @(posedge clk);
      #1;
      check("rst_outputs", int'({mf_update, bit_valid, bit_data, preamble_det, locked}), 0);
      check("rst_bit_cnt", int'(bit_cnt), 0);
      rst  = 1'b1;
      hits = 0;
      for (int i = 0; i < 100; i++) begin
         step(1'b0);
         if (mf_update || bit_valid || bit_data || preamble_det || locked || (bit_cnt != 0)) hits++;
      end
      check("idle_quiet", hits, 0);

      // ideal aligned alternating stream: lock, 20-bit budget, relock
      restart();
      hits = 0;
      for (int s = 0; s < 30; s++) begin
         for (int ph = 0; ph < 16; ph++) begin
            step(tbl[s].d != 0);
            if (ph == 8) check("ideal_mf_update", int'(mf_update), 1);
            else if (mf_update) hits++;
            if (ph == 9) begin
               check("ideal_bit_valid", int'(bit_valid), tbl[s].bv);
               check("ideal_bit_data", int'(bit_data), tbl[s].bd);
               check("ideal_preamble_det", int'(preamble_det), tbl[s].pd);
               check("ideal_locked", int'(locked), tbl[s].lk);
               check("ideal_bit_cnt", int'(bit_cnt), tbl[s].cnt);
            end
            if (ph == 10) check("ideal_pulse_width", int'({bit_valid, preamble_det}), 0);
         end
      end
      check("ideal_stray_mf_update", hits, 0);

      // late and early transition phases
`ifdef MF_TIMING_TRACK_EN
      phase_run("late", 3, 17, 17, 17, 16, 16);
      phase_run("early", 13, 15, 15, 15, 16, 16);
`else
      phase_run("late", 3, 16, 16, 16, 16, 16);
      phase_run("early", 13, 16, 16, 16, 16, 16);
`endif

      // lock loss: alternate through symbol 9, then hold high
      restart();
      for (int n = 0; n < 314; n++) begin
         k = n / 16;
         step((n < 160) ? ((k % 2) == 1) : 1'b1);
         if (n == 121) check("loss_lock_det", int'({preamble_det, locked}), 3);
         if (n == 281) check("loss_bit_cnt", int'(bit_cnt), 10);
         if (n == 289) check("loss_still_locked", int'(locked), 1);
`ifdef MF_TIMING_TRACK_EN
         if (n == 290) check("loss_drop", int'(locked), 0);
         if (n == 313) check("loss_search_unlocked", int'(locked), 0);
`else
         if (n == 290) check("loss_no_drop", int'(locked), 1);
         if (n == 313) check("loss_no_drop_later", int'(locked), 1);
`endif
         if (n == 312) check("loss_search_mf_update", int'(mf_update), 1);
      end

      // preamble match in the cycle en falls is ignored
      restart();
      for (int n = 0; n <= 120; n++) step(((n / 16) % 2) == 1);
      en = 1'b0;
      step(1'b0);
      check("en_fall_match_ignored", int'({preamble_det, locked}), 0);

      // en low mid-LOCKED at bit_cnt 5, then re-enable needs a fresh preamble
      restart();
      for (int n = 0; n <= 201; n++) step(((n / 16) % 2) == 1);
      check("mid_bit_cnt", int'(bit_cnt), 5);
      check("mid_bit_valid", int'(bit_valid), 1);
      en = 1'b0;
      step(1'b0);
      check("mid_off_flags", int'({mf_update, bit_valid, bit_data, preamble_det, locked}), 0);
      check("mid_off_bit_cnt", int'(bit_cnt), 0);
      restart();
      hits = 0;
      for (int n = 0; n <= 297; n++) begin
         k = n / 16;
         step((k < 10) ? 1'b0 : (((k - 10) % 2) == 1));
         if ((n < 281) && (bit_valid || preamble_det || locked)) hits++;
         if (n == 281) check("reen_preamble_det", int'({preamble_det, locked}), 3);
         if (n == 297) begin
            check("reen_bit_valid", int'(bit_valid), 1);
            check("reen_bit_cnt", int'(bit_cnt), 1);
            check("reen_bit_data", int'(bit_data), 0);
         end
      end
      check("reen_no_early_bits", hits, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
